// File: rtl/ipg_req_proc.sv
// Inter-packet-gap request processor: reassembles read/write requests from IPG fragments
// and serialises replies into gap-sized chunks. Optional IPG_PROC_TIMEOUT_EN abandons stalled frames.
module ipg_req_proc #(
  parameter int DATA_WIDTH     = 64,
  parameter int ADDR_WIDTH     = 64,
  parameter int PAYLOAD_WIDTH  = 512,
  parameter int TIMEOUT_CYCLES = 1024,
  localparam int LW = $clog2(DATA_WIDTH) + 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     rx_ipg_valid,
  input  logic [DATA_WIDTH-1:0]    rx_ipg_data,
  input  logic [LW-1:0]            rx_len,
  output logic                     req_valid,
  input  logic                     req_ready,
  output logic                     req_write,
  output logic [6:0]               req_tag,
  output logic [ADDR_WIDTH-1:0]    req_addr,
  output logic [PAYLOAD_WIDTH-1:0] req_data,
  input  logic                     rsp_valid,
  output logic                     rsp_ready,
  input  logic [6:0]               rsp_tag,
  input  logic [PAYLOAD_WIDTH-1:0] rsp_data,
  input  logic [LW-1:0]            tx_gap_len,
  output logic [DATA_WIDTH-1:0]    tx_ipg_data,
  output logic [LW-1:0]            tx_ipg_len,
  output logic                     rx_drop,
  output logic [15:0]              drop_count
);

  localparam int RD_LEN  = 8 + ADDR_WIDTH;
  localparam int WR_LEN  = RD_LEN + PAYLOAD_WIDTH;
  localparam int FRAME_W = WR_LEN;
  localparam int CNT_W   = $clog2(FRAME_W + DATA_WIDTH + 1);
  localparam int RSP_W   = 8 + PAYLOAD_WIDTH;
  localparam int REM_W   = $clog2(RSP_W + 1);

  typedef enum logic [1:0] {S_IDLE, S_ACCUM, S_ISSUE} state_t;

  state_t                   state_reg, state_next;
  logic [FRAME_W-1:0]       frame_reg, frame_next, frame_base, frame_merged;
  logic [CNT_W-1:0]         count_reg, count_next, count_base, count_sum, frame_len;
  logic [LW-1:0]            rx_floor, rx_eff;
  logic [DATA_WIDTH-1:0]    rx_mask, rx_frag;
  logic                     rx_active, cur_write, load_req, drop_next;

  logic                     req_valid_reg, req_write_reg;
  logic [6:0]               req_tag_reg;
  logic [ADDR_WIDTH-1:0]    req_addr_reg;
  logic [PAYLOAD_WIDTH-1:0] req_data_reg;
  logic                     rx_drop_reg;
  logic [15:0]              drop_count_reg;

  logic                     busy_reg, rsp_fire, ser_active;
  logic [RSP_W-1:0]         shift_reg, ser_src;
  logic [REM_W-1:0]         rem_reg, ser_rem, ser_n, rem_next;
  logic [LW-1:0]            gap_floor, gap_eff;
  logic [DATA_WIDTH-1:0]    tx_mask;
  logic [DATA_WIDTH-1:0]    tx_data_reg;
  logic [LW-1:0]            tx_len_reg;

  // Sub-byte length bits are deliberately ignored on both paths.
  logic [5:0] unused_low_bits;
  assign unused_low_bits = {rx_len[2:0], tx_gap_len[2:0]};

  // Fragment length: whole bytes only, clamped to the chunk width.
  assign rx_floor  = {rx_len[LW-1:3], 3'b000};
  assign rx_eff    = (rx_floor > LW'(DATA_WIDTH)) ? LW'(DATA_WIDTH) : rx_floor;
  assign gap_floor = {tx_gap_len[LW-1:3], 3'b000};
  assign gap_eff   = (gap_floor > LW'(DATA_WIDTH)) ? LW'(DATA_WIDTH) : gap_floor;

  generate
    for (genvar gi = 0; gi < DATA_WIDTH; gi++) begin : g_mask
      assign rx_mask[gi] = (rx_eff > LW'(gi));
      assign tx_mask[gi] = (ser_n > REM_W'(gi));
    end
  endgenerate

  assign rx_frag    = rx_ipg_data & rx_mask;
  assign rx_active  = rx_ipg_valid && (rx_eff != '0);
  assign cur_write  = (state_reg == S_IDLE) ? rx_frag[0] : frame_reg[0];
  assign frame_len  = cur_write ? CNT_W'(WR_LEN) : CNT_W'(RD_LEN);
  assign frame_base = (state_reg == S_IDLE) ? '0 : frame_reg;
  assign count_base = (state_reg == S_IDLE) ? '0 : count_reg;
  // Bits shifted past the top of the frame buffer fall off here; they are the excess.
  assign frame_merged = frame_base | (FRAME_W'(rx_frag) << count_base);
  assign count_sum    = count_base + CNT_W'(rx_eff);

`ifdef IPG_PROC_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [TO_W-1:0] idle_cnt_reg, idle_cnt_next;
`else
  localparam int unused_timeout_cycles = TIMEOUT_CYCLES;
`endif

  always_comb begin
    state_next = state_reg;
    frame_next = frame_reg;
    count_next = count_reg;
    load_req   = 1'b0;
    drop_next  = 1'b0;
`ifdef IPG_PROC_TIMEOUT_EN
    idle_cnt_next = '0;
`endif
    case (state_reg)
      S_IDLE, S_ACCUM: begin
        if (rx_active) begin
          frame_next = frame_merged;
          count_next = count_sum;
          drop_next  = (count_sum > frame_len);
          if (count_sum >= frame_len) begin
            state_next = S_ISSUE;
            load_req   = 1'b1;
          end else begin
            state_next = S_ACCUM;
          end
        end
`ifdef IPG_PROC_TIMEOUT_EN
        else if (state_reg == S_ACCUM) begin
          if (idle_cnt_reg == TO_W'(TIMEOUT_CYCLES - 1)) begin
            state_next = S_IDLE;
            count_next = '0;
            drop_next  = 1'b1;
          end else begin
            idle_cnt_next = idle_cnt_reg + TO_W'(1);
          end
        end
`endif
      end
      S_ISSUE: begin
        // Anything arriving while a request is pending has nowhere to go.
        drop_next = rx_active;
        if (req_valid_reg && req_ready) begin
          state_next = S_IDLE;
          count_next = '0;
        end
      end
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg      <= S_IDLE;
      frame_reg      <= '0;
      count_reg      <= '0;
      req_valid_reg  <= 1'b0;
      req_write_reg  <= 1'b0;
      req_tag_reg    <= '0;
      req_addr_reg   <= '0;
      req_data_reg   <= '0;
      rx_drop_reg    <= 1'b0;
      drop_count_reg <= '0;
    end else begin
      state_reg     <= state_next;
      frame_reg     <= frame_next;
      count_reg     <= count_next;
      req_valid_reg <= (state_next == S_ISSUE);
      if (load_req) begin
        req_write_reg <= cur_write;
        req_tag_reg   <= frame_merged[7:1];
        req_addr_reg  <= frame_merged[8 +: ADDR_WIDTH];
        req_data_reg  <= cur_write ? frame_merged[FRAME_W-1:RD_LEN] : '0;
      end
      rx_drop_reg <= drop_next;
      if (drop_next && (drop_count_reg != 16'hFFFF))
        drop_count_reg <= drop_count_reg + 16'd1;
    end
  end

`ifdef IPG_PROC_TIMEOUT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) idle_cnt_reg <= '0;
    else     idle_cnt_reg <= idle_cnt_next;
  end
`endif

  // Serialiser: the handshake cycle already emits the first chunk straight from rsp_data.
  assign rsp_fire   = rsp_valid && !busy_reg;
  assign ser_active = busy_reg || rsp_fire;
  assign ser_src    = busy_reg ? shift_reg : {rsp_data, rsp_tag, 1'b1};
  assign ser_rem    = busy_reg ? rem_reg : REM_W'(RSP_W);
  assign ser_n      = (ser_rem < REM_W'(gap_eff)) ? ser_rem : REM_W'(gap_eff);
  assign rem_next   = ser_rem - ser_n;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy_reg    <= 1'b0;
      shift_reg   <= '0;
      rem_reg     <= '0;
      tx_data_reg <= '0;
      tx_len_reg  <= '0;
    end else if (ser_active) begin
      busy_reg    <= (rem_next != '0);
      shift_reg   <= ser_src >> ser_n;
      rem_reg     <= rem_next;
      tx_data_reg <= ser_src[DATA_WIDTH-1:0] & tx_mask;
      tx_len_reg  <= LW'(ser_n);
    end else begin
      tx_data_reg <= '0;
      tx_len_reg  <= '0;
    end
  end

  assign req_valid   = req_valid_reg;
  assign req_write   = req_write_reg;
  assign req_tag     = req_tag_reg;
  assign req_addr    = req_addr_reg;
  assign req_data    = req_data_reg;
  assign rx_drop     = rx_drop_reg;
  assign drop_count  = drop_count_reg;
  assign rsp_ready   = !busy_reg;
  assign tx_ipg_data = tx_data_reg;
  assign tx_ipg_len  = tx_len_reg;

endmodule

// File: doc/ipg_req_proc.md
# ipg_req_proc

Parametrised inter-packet-gap request processor for the EDM PHY path. It reassembles memory read and write requests from variable-length IPG fragments and issues each one on a ready/valid request port. It also serialises memory replies back into outbound IPG chunks sized to the gap available each cycle. It generalises the single-width debug IPG processor to configurable data, address and payload widths, with tagged requests, backpressure and drop accounting.

## Interface
- DATA_WIDTH, 64, IPG chunk width in bits; multiple of 8.
- ADDR_WIDTH, 64, request address width.
- PAYLOAD_WIDTH, 512, write/reply payload width; multiple of 8.
- TIMEOUT_CYCLES, 1024, partial-request abandon threshold; used only with the timeout macro.
- LW = $clog2(DATA_WIDTH)+1 (local).
- clk  in  1  sole clock.
- rst  in  1  asynchronous, active-high reset.
- rx_ipg_valid  in  1  fragment present this cycle.
- rx_ipg_data  in  DATA_WIDTH  fragment, LSB-first packed.
- rx_len  in  LW  valid bits in rx_ipg_data.
- req_valid / req_ready  out / in  1  request handshake.
- req_write  out  1  1 = write, 0 = read.
- req_tag  out  7  request tag.
- req_addr  out  ADDR_WIDTH  request address.
- req_data  out  PAYLOAD_WIDTH  write payload; zero for reads.
- rsp_valid / rsp_ready  in / out  1  reply handshake.
- rsp_tag  in  7  reply tag.
- rsp_data  in  PAYLOAD_WIDTH  reply payload.
- tx_gap_len  in  LW  outbound gap bits available this cycle.
- tx_ipg_data  out  DATA_WIDTH  outbound chunk, LSB-first.
- tx_ipg_len  out  LW  valid bits in tx_ipg_data; 0 = nothing sent.
- rx_drop  out  1  one-cycle pulse when bits are discarded.
- drop_count  out  16  saturating count of rx_drop pulses.

## Operation
- Request frame layout, LSB-first:
  - header byte: bit0 = write, bits[7:1] = tag.
  - then ADDR_WIDTH address bits.
  - then PAYLOAD_WIDTH payload bits, writes only.
  - Read length = 8+ADDR_WIDTH bits; write length = 8+ADDR_WIDTH+PAYLOAD_WIDTH bits.
- rx_len handling:
  - rx_len[2:0] is ignored (floor to whole bytes).
  - Values above DATA_WIDTH are clamped to DATA_WIDTH.
  - A valid fragment with effective length 0 is ignored and does not count as a drop.
- Receive FSM:
  - IDLE: a fragment starts a frame, header taken from byte 0, bits stored at offset 0, bit count = length. Go to ACCUM, or to ISSUE if the frame is already complete.
  - ACCUM: each fragment is written at the current bit offset and the count is increased. When count ≥ frame length, go to ISSUE. Excess bits are discarded and raise rx_drop.
  - ISSUE: req_* are held stable with req_valid=1. On req_valid&&req_ready, go to IDLE and clear the count. Any fragment arriving in ISSUE, including the handshake cycle, is discarded with rx_drop.
- Reply serialiser:
  - rsp_ready=1 only while the serialiser is empty.
  - On handshake, load the frame {rsp_data, rsp_tag, 1'b1} (520 bits at default widths); remaining = 8+PAYLOAD_WIDTH.
  - Each cycle, emit n = min(remaining, floor8(tx_gap_len), DATA_WIDTH) bits, lowest first, in tx_ipg_data[n-1:0]. Unused upper bits are 0. tx_ipg_len = n.
  - When remaining reaches 0 the serialiser is empty again, and rsp_ready rises on the next cycle.
- drop_count saturates at 16'hFFFF.

## Timing
- Reset values: req_valid=0, req_* all 0, rsp_ready=1, tx_ipg_data=0, tx_ipg_len=0, rx_drop=0, drop_count=0, FSM=IDLE, serialiser empty.
- Reset asserted mid-frame or mid-reply discards all partial state immediately.
- Request latency: req_valid rises on the cycle after the completing fragment is sampled.
- Reply latency: the first chunk appears on the cycle after the rsp handshake. Outputs are registered. With tx_gap_len=0 the serialiser stalls and emits tx_ipg_len=0.
- rx_drop pulses in the cycle after the offending fragment, at most once per fragment.
- The receive and reply paths are independent; simultaneous activity on both has no interaction.

## Configuration
- IPG_PROC_TIMEOUT_EN defined:
  - An idle counter runs while in ACCUM and resets on each accepted fragment.
  - When it reaches TIMEOUT_CYCLES, the partial frame is abandoned, the FSM returns to IDLE, and rx_drop pulses once.
- Undefined: ACCUM waits indefinitely; no counter logic is generated.

## Test plan
- Read reassembly:
  - Stimulus: fragment 64'h0011223344556600 with rx_len=56, then 64'h8877 with rx_len=16, req_ready=1.
  - Response: one request with req_write=0, req_tag=0, req_addr=64'h8877112233445566, req_data=0; no drop.
- Write reassembly:
  - Stimulus: header 8'h03, address 64'h1, payload all-8'h5A, sent as nine 64-bit fragments plus one 8-bit fragment.
  - Response: req_write=1, req_tag=1, req_addr=1, req_data all 8'h5A.
- Backpressure:
  - Stimulus: hold req_ready=0 for 5 cycles after a read completes, sending 2 fragments meanwhile.
  - Response: req_* stable throughout, rx_drop pulses twice, drop_count=2, then a single handshake.
- Excess bits:
  - Stimulus: read frame closed by a 64-bit fragment when only 16 bits are needed.
  - Response: request issued correctly, rx_drop=1.
- Reply serialisation:
  - Stimulus: rsp_tag=7'h05, rsp_data all 8'hA5, tx_gap_len=56.
  - Response: ten chunks, nine with tx_ipg_len=56 and a final one with 16. First byte is 8'h0B. rsp_ready returns to 1 afterwards.
- Timeout (macro on, TIMEOUT_CYCLES=16):
  - Stimulus: a 24-bit fragment followed by 16 idle cycles.
  - Response: rx_drop once, FSM back in IDLE, the next fragment is treated as a new header.
